// File: rtl/hash_nonce_scheduler.sv
// hash_nonce_scheduler
//   Sequences the nonce search for the hash generator. Each candidate nonce
//   gets one LOAD cycle (count==0, block assembly loads {entrada, nonce}),
//   then HASH cycles while the core works, then one CHECK cycle comparing the
//   result against the latched target. Reports the winning nonce, exhaustion
//   of the nonce range, or a hash-core timeout.
//
//   Optional feature macro: HASH_SCHED_ABORT_EN
//     When defined, an 'abort' input forces DONE from LOAD/HASH/CHECK with
//     found=0, error=0 and the current nonce held.
module hash_nonce_scheduler #(
    parameter int unsigned HASH_W    = 24,
    parameter logic [31:0] MAX_NONCE = 32'hFFFF_FFFF,
    parameter int unsigned TIMEOUT   = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [HASH_W-1:0] target,
    input  logic [HASH_W-1:0] hash_in,
    input  logic              hash_valid,
`ifdef HASH_SCHED_ABORT_EN
    input  logic              abort,
`endif
    output logic [31:0]       nonce,
    output logic [5:0]        count,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [31:0]       golden_nonce,
    output logic              error
);

    // count parks at all-ones whenever no nonce is being loaded or hashed,
    // so the block assembly never sees a spurious load cycle.
    localparam logic [5:0] COUNT_PARK  = 6'h3F;
    localparam logic [5:0] TIMEOUT_CNT = 6'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HASH,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       nonce_q, nonce_d;
    logic [5:0]        count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              found_q, found_d;
    logic              error_q, error_d;
    logic [31:0]       golden_q, golden_d;
    logic [HASH_W-1:0] target_q, target_d;
    logic [HASH_W-1:0] hash_q, hash_d;

    // Next-state and next-output computation for the search sequencer.
    always_comb begin
        state_d  = state_q;
        nonce_d  = nonce_q;
        count_d  = COUNT_PARK;
        found_d  = found_q;
        error_d  = error_q;
        golden_d = golden_q;
        target_d = target_q;
        hash_d   = hash_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    target_d = target;
                    nonce_d  = '0;
                    found_d  = 1'b0;
                    error_d  = 1'b0;
                    count_d  = '0;
                    state_d  = S_LOAD;
                end
            end

            S_LOAD: begin
                count_d = 6'd1;
                state_d = S_HASH;
            end

            S_HASH: begin
                if (hash_valid) begin
                    hash_d  = hash_in;
                    state_d = S_CHECK;
                end else if (count_q == TIMEOUT_CNT) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + 6'd1;
                end
            end

            S_CHECK: begin
                if (hash_q < target_q) begin
                    found_d  = 1'b1;
                    golden_d = nonce_q;
                    state_d  = S_DONE;
                end else if (nonce_q == MAX_NONCE) begin
                    found_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    nonce_d = nonce_q + 32'd1;
                    count_d = '0;
                    state_d = S_LOAD;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef HASH_SCHED_ABORT_EN
        // Abort overrides whatever the busy states decided this cycle.
        if (abort && (state_q == S_LOAD || state_q == S_HASH || state_q == S_CHECK)) begin
            state_d  = S_DONE;
            found_d  = 1'b0;
            error_d  = 1'b0;
            nonce_d  = nonce_q;
            golden_d = golden_q;
            hash_d   = hash_q;
            count_d  = COUNT_PARK;
        end
`endif

        busy_d = (state_d == S_LOAD) || (state_d == S_HASH) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            nonce_q  <= '0;
            count_q  <= COUNT_PARK;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            golden_q <= '0;
            target_q <= '0;
            hash_q   <= '0;
        end else begin
            state_q  <= state_d;
            nonce_q  <= nonce_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            error_q  <= error_d;
            golden_q <= golden_d;
            target_q <= target_d;
            hash_q   <= hash_d;
        end
    end

    assign nonce        = nonce_q;
    assign count        = count_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign found        = found_q;
    assign golden_nonce = golden_q;
    assign error        = error_q;

endmodule

// File: tb/tb_hash_nonce_scheduler.sv
// tb_hash_nonce_scheduler
//   Drives the scheduler with a scripted hash core (per-nonce response cycle
//   and hash value) and compares against a per-search reference model that
//   predicts the outcome, busy-cycle total, load count and final outputs.
module tb_hash_nonce_scheduler;

    localparam int MAX_N = 5;

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] target;
    logic [23:0] hash_in;
    logic        hash_valid;
    logic [31:0] nonce;
    logic [5:0]  count;
    logic        busy;
    logic        done;
    logic        found;
    logic [31:0] golden_nonce;
    logic        error;

    hash_nonce_scheduler #(
        .HASH_W    (24),
        .MAX_NONCE (32'd5),
        .TIMEOUT   (63)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .target       (target),
        .hash_in      (hash_in),
        .hash_valid   (hash_valid),
        .nonce        (nonce),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .golden_nonce (golden_nonce),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Hash core script: cycle count at which the core answers (0 = never)
    // and the hash it returns, per nonce.
    int          plan_cnt  [0:MAX_N];
    logic [23:0] plan_hash [0:MAX_N];
    logic [31:0] g_golden;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check_eq({pfx, "_count"}, 64'(count), 64'h3F);
        check_eq({pfx, "_nonce"}, 64'(nonce), 64'h0);
        check_eq({pfx, "_busy"}, 64'(busy), 64'h0);
        check_eq({pfx, "_done"}, 64'(done), 64'h0);
        check_eq({pfx, "_found"}, 64'(found), 64'h0);
        check_eq({pfx, "_error"}, 64'(error), 64'h0);
        check_eq({pfx, "_golden"}, 64'(golden_nonce), 64'h0);
    endtask

    task automatic run_search(input logic [23:0] tgt, input int rst_nonce);
        int          exp_busy  = 0;
        int          exp_loads = 0;
        logic        exp_found = 1'b0;
        logic        exp_err   = 1'b0;
        logic [31:0] exp_last  = '0;
        int          busy_cnt  = 0;
        int          zero_cnt  = 0;
        int          bad_zero  = 0;
        bit          first     = 1'b1;
        bit          finished  = 1'b0;

        // Reference: walk the nonce range with the scripted core.
        for (int n = 0; n <= MAX_N; n++) begin
            exp_loads++;
            exp_last = 32'(n);
            if (plan_cnt[n] == 0) begin
                exp_err  = 1'b1;
                exp_busy += 1 + 63;
                break;
            end
            exp_busy += plan_cnt[n] + 2;
            if (plan_hash[n] < tgt) begin
                exp_found = 1'b1;
                break;
            end
        end

        @(negedge clk);
        target     = tgt;
        start      = 1'b1;
        hash_valid = 1'b0;

        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (busy) begin
                busy_cnt++;
                if (first) begin
                    check_eq("start_found_clr", 64'(found), 64'h0);
                    check_eq("start_error_clr", 64'(error), 64'h0);
                    first = 1'b0;
                end
            end
            if (count == 6'd0) begin
                if (busy) begin
                    check_eq("load_nonce", 64'(nonce), 64'(zero_cnt));
                    zero_cnt++;
                end else begin
                    bad_zero++;
                end
            end
            if (rst_nonce >= 0 && busy && nonce == 32'(rst_nonce) && count == 6'd10) begin
                reset      = 1'b1;
                start      = 1'b0;
                hash_valid = 1'b0;
                @(negedge clk);
                check_reset_values("midrun_rst");
                reset    = 1'b0;
                g_golden = '0;
                return;
            end
            // Busy-time noise: start and target must be ignored.
            start      = 1'($urandom_range(0, 1));
            target     = 24'($urandom);
            hash_in    = 24'($urandom);
            hash_valid = 1'b0;
            if (busy && nonce <= 32'(MAX_N) && plan_cnt[nonce[2:0]] != 0 &&
                count == 6'(plan_cnt[nonce[2:0]])) begin
                hash_valid = 1'b1;
                hash_in    = plan_hash[nonce[2:0]];
            end else if (busy && count == 6'd0 && $urandom_range(0, 1) == 1) begin
                // Stray strobe during LOAD carrying a winning hash.
                hash_valid = 1'b1;
                hash_in    = '0;
            end
        end

        start      = 1'b0;
        hash_valid = 1'b0;
        check_eq("search_ended", 64'(finished), 64'h1);
        if (!finished) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset    = 1'b0;
            g_golden = '0;
            return;
        end

        if (exp_found) g_golden = exp_last;
        check_eq("done", 64'(done), 64'h1);
        check_eq("done_busy", 64'(busy), 64'h0);
        check_eq("found", 64'(found), 64'(exp_found));
        check_eq("error", 64'(error), 64'(exp_err));
        check_eq("final_nonce", 64'(nonce), 64'(exp_last));
        check_eq("golden", 64'(golden_nonce), 64'(g_golden));
        check_eq("done_count", 64'(count), 64'h3F);
        check_eq("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        check_eq("load_cycles", 64'(zero_cnt), 64'(exp_loads));
        check_eq("zero_outside_load", 64'(bad_zero), 64'h0);

        // DONE holds against stray strobes and target changes.
        repeat (3) begin
            target     = 24'($urandom);
            hash_valid = 1'b1;
            hash_in    = '0;
            @(negedge clk);
            check_eq("hold_done", 64'(done), 64'h1);
            check_eq("hold_found", 64'(found), 64'(exp_found));
            check_eq("hold_error", 64'(error), 64'(exp_err));
            check_eq("hold_nonce", 64'(nonce), 64'(exp_last));
            check_eq("hold_golden", 64'(golden_nonce), 64'(g_golden));
            check_eq("hold_count", 64'(count), 64'h3F);
        end
        hash_valid = 1'b0;
    endtask

    task automatic fill_miss(input int cnt, input logic [23:0] h);
        for (int n = 0; n <= MAX_N; n++) begin
            plan_cnt[n]  = cnt;
            plan_hash[n] = h;
        end
    endtask

    initial begin
        logic [23:0] tgt;
        int          m;

        reset      = 1'b1;
        start      = 1'b0;
        hash_valid = 1'b0;
        target     = '0;
        hash_in    = '0;
        g_golden   = '0;

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        repeat (10) begin
            hash_valid = 1'($urandom_range(0, 1));
            hash_in    = 24'($urandom);
            @(negedge clk);
            check_eq("idle_count_nonzero", 64'(count == 6'd0), 64'h0);
            check_eq("idle_busy", 64'(busy), 64'h0);
        end
        hash_valid = 1'b0;

        // Immediate hit on nonce 0, core answers at count 20.
        fill_miss(5, 24'hFFFFFF);
        plan_cnt[0]  = 20;
        plan_hash[0] = 24'h0FFFFF;
        run_search(24'h100000, -1);

        // Multi-nonce: hit on the last nonce of the range.
        for (int n = 0; n < MAX_N; n++) begin
            plan_cnt[n]  = $urandom_range(1, 8);
            plan_hash[n] = 24'hFFFFFF;
        end
        plan_cnt[MAX_N]  = 4;
        plan_hash[MAX_N] = 24'h00000F;
        run_search(24'h000010, -1);

        // Exhaustion; hash equal to target is not a hit.
        fill_miss(2, 24'hFFFFFF);
        plan_hash[2] = 24'h000010;
        run_search(24'h000010, -1);

        // Timeout on nonce 1, then restart with a working core.
        fill_miss(3, 24'hFFFFFF);
        plan_cnt[1] = 0;
        run_search(24'h000100, -1);
        fill_miss(3, 24'h000000);
        run_search(24'h000001, -1);

        // Reset while hashing nonce 2, then a fresh search from IDLE.
        fill_miss(15, 24'hFFFFFF);
        run_search(24'h000010, 2);
        fill_miss(1, 24'hFFFFFF);
        plan_hash[1] = 24'h000000;
        run_search(24'h000010, -1);

        // Randomized searches.
        for (int t = 0; t < 30; t++) begin
            tgt = 24'($urandom);
            m   = $urandom_range(0, 5);
            if (m == 0) tgt = '0;
            if (m == 1) tgt = 24'hFFFFFF;
            for (int n = 0; n <= MAX_N; n++) begin
                m = $urandom_range(0, 11);
                if (m == 0)      plan_cnt[n] = 0;
                else if (m == 1) plan_cnt[n] = 1;
                else if (m == 2) plan_cnt[n] = 63;
                else             plan_cnt[n] = $urandom_range(1, 12);
                m = $urandom_range(0, 7);
                if (m < 2 && tgt != 24'd0)
                    plan_hash[n] = 24'($urandom_range(0, 32'(tgt) - 1));
                else if (m == 2)
                    plan_hash[n] = tgt;
                else
                    plan_hash[n] = 24'($urandom_range(32'(tgt), 32'hFFFFFF));
            end
            run_search(tgt, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
